// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite subordinate in front of a word-addressed on-chip SRAM.
// Inserts WAIT_STATES per OKAY beat and answers illegal accesses with the two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          write_q, write_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] acc_idx;
  logic          accept;
  logic          legal;
  logic          commit;
  logic          unused_bits;

  // Offsets below BASE_ADDR wrap to large values, so one range check covers both bounds.
  assign offset      = HADDR - BASE_ADDR;
  assign acc_idx     = offset[AW+1:2];
  assign accept      = HSEL & HREADY & HTRANS[1];
  assign legal       = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) && (offset[31:AW+2] == '0);
  assign commit      = (state_q == ST_LAST) && write_q;
  assign unused_bits = ^{HBURST, HTRANS[0], offset[1:0]};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    hrdata_d   = hrdata_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_LAST;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
        if (accept) begin
          if (legal) begin
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
            end else begin
              state_d = ST_LAST;
            end
            wait_cnt_d = WAIT_LOAD;
            write_d    = HWRITE;
            idx_d      = acc_idx;
            // A write committing on this same edge must be seen by the read.
            if (!HWRITE) begin
              if (commit && (idx_q == acc_idx)) begin
                hrdata_d = HWDATA;
              end else begin
                hrdata_d = mem[acc_idx];
              end
            end
          end else begin
            state_d = ST_ERR1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      hrdata_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      hrdata_q   <= hrdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      mem[idx_q] <= HWDATA;
    end
  end

  assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: one zero-wait instance driven from a vector table,
// one single-wait instance driven by hand-written multi-cycle sequences.
module tb_ahb3lite_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] S_WORD   = 3'b010;
  localparam int         NUM_VEC  = 24;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expReady;
    logic        expResp;
    logic [31:0] expRdata;
  } vec_t;

  logic        hclk;
  logic        hresetn;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1;
  logic        hresp0, hresp1;

  int checkCount;
  int failCount;
  vec_t vecs [NUM_VEC];

  ahb3lite_sram_slave #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hreadyout0),
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb3lite_sram_slave #(.DEPTH(256), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut1 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hreadyout1),
    .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic checkOutput(input string name, input logic actReady, input logic actResp,
                             input logic [31:0] actRdata, input logic expReady,
                             input logic expResp, input logic [31:0] expRdata);
    checkCount++;
    if (actReady !== expReady || actResp !== expResp || actRdata !== expRdata) begin
      failCount++;
      $display("[TB] FAIL %s: got ready=%b resp=%b rdata=%h, expected ready=%b resp=%b rdata=%h",
               name, actReady, actResp, actRdata, expReady, expResp, expRdata);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge hclk);
    hsel0  = v.sel;
    hsel1  = 1'b0;
    htrans = v.trans;
    hwrite = v.wr;
    hsize  = S_WORD;
    haddr  = v.addr;
    hwdata = v.wdata;
    #1;
  endtask

  task automatic doCycle1(input logic sel, input logic [1:0] trans, input logic wr,
                          input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input string name, input logic expReady,
                          input logic expResp, input logic [31:0] expRdata);
    @(negedge hclk);
    hsel0  = 1'b0;
    hsel1  = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    hwdata = wdata;
    #1;
    checkOutput(name, hreadyout1, hresp1, hrdata1, expReady, expResp, expRdata);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    hresetn = 1'b0;
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
    hsize = S_WORD; hburst = 3'd0; haddr = 32'h0; hwdata = 32'h0;

    vecs[0]  = '{1'b1, T_NONSEQ, 1'b1, 32'h40, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, T_SEQ,    1'b1, 32'h44, 32'h1,         1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, T_SEQ,    1'b1, 32'h48, 32'h2,         1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, T_SEQ,    1'b1, 32'h4C, 32'h3,         1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, T_NONSEQ, 1'b0, 32'h40, 32'h4,         1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, T_SEQ,    1'b0, 32'h44, 32'h0,         1'b1, 1'b0, 32'h1};
    vecs[6]  = '{1'b1, T_SEQ,    1'b0, 32'h48, 32'h0,         1'b1, 1'b0, 32'h2};
    vecs[7]  = '{1'b1, T_SEQ,    1'b0, 32'h4C, 32'h0,         1'b1, 1'b0, 32'h3};
    vecs[8]  = '{1'b1, T_IDLE,   1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h4};
    vecs[9]  = '{1'b1, T_NONSEQ, 1'b1, 32'h80, 32'h0,         1'b1, 1'b0, 32'h4};
    vecs[10] = '{1'b1, T_NONSEQ, 1'b0, 32'h80, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h4};
    vecs[11] = '{1'b1, T_IDLE,   1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[12] = '{1'b1, T_NONSEQ, 1'b0, 32'h80, 32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[13] = '{1'b1, T_NONSEQ, 1'b1, 32'h80, 32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[14] = '{1'b1, T_IDLE,   1'b0, 32'h0,  32'h1234_5678, 1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[15] = '{1'b1, T_NONSEQ, 1'b0, 32'h80, 32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[16] = '{1'b1, T_IDLE,   1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h1234_5678};
    vecs[17] = '{1'b1, T_NONSEQ, 1'b0, 32'h40, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
    vecs[18] = '{1'b1, T_BUSY,   1'b0, 32'h44, 32'h0,         1'b1, 1'b0, 32'h1};
    vecs[19] = '{1'b1, T_SEQ,    1'b0, 32'h44, 32'h0,         1'b1, 1'b0, 32'h1};
    vecs[20] = '{1'b0, T_NONSEQ, 1'b1, 32'h40, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h2};
    vecs[21] = '{1'b0, T_IDLE,   1'b1, 32'h40, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h2};
    vecs[22] = '{1'b1, T_NONSEQ, 1'b0, 32'h40, 32'h0,         1'b1, 1'b0, 32'h2};
    vecs[23] = '{1'b1, T_IDLE,   1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h1};

    // Reset values while reset is held.
    #12;
    checkOutput("rst_dut0", hreadyout0, hresp0, hrdata0, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_dut1", hreadyout1, hresp1, hrdata1, 1'b1, 1'b0, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // Zero-wait instance: pipelined bursts, forwarding, write-after-read, BUSY and deselect.
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), hreadyout0, hresp0, hrdata0,
                  vecs[i].expReady, vecs[i].expResp, vecs[i].expRdata);
    end

    // One-wait instance: write then read of the same word.
    doCycle1(1'b1, T_NONSEQ, 1'b1, S_WORD, 32'h10, 32'h0,         "t2_wr_addr", 1'b1, 1'b0, 32'h0);
    doCycle1(1'b1, T_NONSEQ, 1'b0, S_WORD, 32'h10, 32'hDEAD_BEEF, "t2_wr_wait", 1'b0, 1'b0, 32'h0);
    doCycle1(1'b1, T_NONSEQ, 1'b0, S_WORD, 32'h10, 32'hDEAD_BEEF, "t2_wr_last", 1'b1, 1'b0, 32'h0);
    doCycle1(1'b1, T_IDLE,   1'b0, S_WORD, 32'h0,  32'h0,         "t2_rd_wait", 1'b0, 1'b0, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_IDLE,   1'b0, S_WORD, 32'h0,  32'h0,         "t2_rd_last", 1'b1, 1'b0, 32'hDEAD_BEEF);

    // Error responses: out of range, bad size, misaligned write, then a legal read.
    doCycle1(1'b1, T_NONSEQ, 1'b0, S_WORD, 32'h400, 32'h0,        "t5_oob_addr",  1'b1, 1'b0, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_NONSEQ, 1'b0, 3'b001, 32'h0,   32'h0,        "t5_oob_err1",  1'b0, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_NONSEQ, 1'b0, 3'b001, 32'h0,   32'h0,        "t5_oob_err2",  1'b1, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_NONSEQ, 1'b0, S_WORD, 32'h2,   32'h0,        "t5_size_err1", 1'b0, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_NONSEQ, 1'b0, S_WORD, 32'h2,   32'h0,        "t5_size_err2", 1'b1, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_NONSEQ, 1'b1, S_WORD, 32'h11,  32'h0,        "t5_mis_err1",  1'b0, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_NONSEQ, 1'b1, S_WORD, 32'h11,  32'h0,        "t5_mis_err2",  1'b1, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_IDLE,   1'b0, S_WORD, 32'h0,   32'h0BAD_0BAD, "t5_wr_err1",  1'b0, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_NONSEQ, 1'b0, S_WORD, 32'h10,  32'h0BAD_0BAD, "t5_wr_err2",  1'b1, 1'b1, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_IDLE,   1'b0, S_WORD, 32'h0,   32'h0,        "t5_ok_wait",   1'b0, 1'b0, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_IDLE,   1'b0, S_WORD, 32'h0,   32'h0,        "t5_ok_last",   1'b1, 1'b0, 32'hDEAD_BEEF);

    // Reset in the middle of a write's wait state drops the write.
    doCycle1(1'b1, T_NONSEQ, 1'b1, S_WORD, 32'h10, 32'h0, "t1_wr_addr", 1'b1, 1'b0, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_IDLE, 1'b0, S_WORD, 32'h0, 32'h5555_5555, "t1_wr_wait", 1'b0, 1'b0, 32'hDEAD_BEEF);
    #2;
    hresetn = 1'b0;
    #1;
    checkOutput("t1_async_rst_dut1", hreadyout1, hresp1, hrdata1, 1'b1, 1'b0, 32'h0);
    checkOutput("t1_async_rst_dut0", hreadyout0, hresp0, hrdata0, 1'b1, 1'b0, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    doCycle1(1'b1, T_NONSEQ, 1'b0, S_WORD, 32'h10, 32'h0, "t1_rd_addr", 1'b1, 1'b0, 32'h0);
    doCycle1(1'b1, T_IDLE,   1'b0, S_WORD, 32'h0,  32'h0, "t1_rd_wait", 1'b0, 1'b0, 32'hDEAD_BEEF);
    doCycle1(1'b1, T_IDLE,   1'b0, S_WORD, 32'h0,  32'h0, "t1_rd_last", 1'b1, 1'b0, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
